// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared opcodes, state encoding and decode helpers
package mem_access_ctrl_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  function automatic logic op_is_load(input logic [4:0] major);
    return major == OP_LOAD;
  endfunction

  function automatic logic op_is_store(input logic [4:0] major);
    return major == OP_STORE;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_counter.sv
// rtl/mem_access_ctrl_timeout_counter.sv - saturating ACCESS-cycle counter with terminal count
module timeout_counter #(
  parameter int TIMEOUT = 15,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  // Holding at the terminal value keeps the counter from ever wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != TC_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - stalls the PC around load/store data-memory accesses
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_enable,
  output logic       reg_write_load,
  output logic       busy,
  output logic       bus_err
);

  state_e state_q, state_d;
  logic   is_store_q, is_store_d;
  logic   dec_load, dec_store, dec_mem;
  logic   cnt_clear, cnt_enable, cnt_tc;
  logic   unused_opcode_bits;

  assign dec_load           = op_is_load(opcode[6:2]);
  assign dec_store          = op_is_store(opcode[6:2]);
  assign dec_mem            = dec_load | dec_store;
  assign unused_opcode_bits = ^opcode[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // An ack on the terminal ACCESS cycle still completes the access.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dec_mem) begin
          state_d    = ST_ACCESS;
          is_store_d = dec_store;
          cnt_clear  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_tc) begin
          state_d = ST_ERR;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req        = (state_q == ST_ACCESS);
    mem_we         = (state_q == ST_ACCESS) && is_store_q;
    pc_enable      = ((state_q == ST_IDLE) && !dec_mem) || (state_q == ST_DONE);
    reg_write_load = pc_enable;
    busy           = (state_q == ST_ACCESS) || (state_q == ST_DONE);
    bus_err        = (state_q == ST_ERR);
  end

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .tc_o     (cnt_tc)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with TIMEOUT=4
module tb_mem_access_ctrl;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = OP_R;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, pc_enable, reg_write_load, busy, bus_err;

  mem_access_ctrl #(
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .mem_ack        (mem_ack),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .pc_enable      (pc_enable),
    .reg_write_load (reg_write_load),
    .busy           (busy),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] exp;
    int         idx;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       cur;
  logic [5:0] act;
  int         checks = 0;
  int         passed = 0;
  int         step_n = 0;

  // Expected vector bits: {mem_req, mem_we, pc_enable, reg_write_load, busy, bus_err}
  task automatic step(input logic r, input logic [6:0] op, input logic ack, input logic [5:0] exp);
    @(posedge clk);
    #1;
    rst     = r;
    opcode  = op;
    mem_ack = ack;
    sb_q.push_back('{exp: exp, idx: step_n});
    step_n++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = {mem_req, mem_we, pc_enable, reg_write_load, busy, bus_err};
      checks++;
      if (act === cur.exp) begin
        passed++;
      end else begin
        $display("FAIL step%0d req/we/pc/rwl/busy/err got %b want %b", cur.idx, act, cur.exp);
      end
    end
  end

  initial begin
    // reset with non-memory opcode
    step(1, OP_R, 0, 6'b001100);
    step(0, OP_R, 0, 6'b001100);
    // load, ack on 3rd ACCESS cycle
    step(0, OP_L, 0, 6'b000000);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 1, 6'b100010);
    step(0, OP_L, 0, 6'b001110);
    // store, ack on 1st ACCESS cycle
    step(0, OP_S, 0, 6'b000000);
    step(0, OP_S, 1, 6'b110010);
    step(0, OP_S, 0, 6'b001110);
    step(0, OP_R, 0, 6'b001100);
    // back-to-back loads; second acked on terminal cycle
    step(0, OP_L, 0, 6'b000000);
    step(0, OP_L, 1, 6'b100010);
    step(0, OP_L, 0, 6'b001110);
    step(0, OP_L, 0, 6'b000000);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 1, 6'b100010);
    step(0, OP_L, 0, 6'b001110);
    // stray ack in IDLE
    step(0, OP_R, 1, 6'b001100);
    step(0, OP_R, 0, 6'b001100);
    // timeout into ERR, stray ack ignored, then reset
    step(0, OP_L, 0, 6'b000000);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_L, 0, 6'b100010);
    step(0, OP_R, 0, 6'b000001);
    step(0, OP_R, 1, 6'b000001);
    step(0, OP_R, 0, 6'b000001);
    step(1, OP_R, 0, 6'b001100);
    step(0, OP_R, 0, 6'b001100);
    // reset in 2nd ACCESS cycle aborts without DONE
    step(0, OP_L, 0, 6'b000000);
    step(0, OP_L, 0, 6'b100010);
    step(1, OP_L, 0, 6'b000000);
    step(0, OP_R, 0, 6'b001100);
    step(0, OP_R, 1, 6'b001100);
    step(0, OP_R, 0, 6'b001100);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain %0d entries left want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 15, max ACCESS cycles awaiting mem_ack (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all flops rising-edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: opcode  input  7  opcode of current instruction.
REQ-005 SHALL have port: mem_ack  input  1  data memory completion, single-cycle pulse.
REQ-006 SHALL have port: mem_req  output  1  data memory access request.
REQ-007 SHALL have port: mem_we  output  1  store (1) / load (0) qualifier for mem_req.
REQ-008 SHALL have port: pc_enable  output  1  PC advance enable; low = stall.
REQ-009 SHALL have port: reg_write_load  output  1  register-file write gate.
REQ-010 SHALL have port: busy  output  1  memory access in progress.
REQ-011 SHALL have port: bus_err  output  1  sticky timeout flag.

Function
REQ-012 SHALL decode load as opcode[6:2]==5'b00000 and store as opcode[6:2]==5'b01000; all other opcodes are non-memory.
REQ-013 SHALL implement states IDLE, ACCESS, DONE, ERR in a registered state machine.
REQ-014 IDLE: load/store -> ACCESS at next edge, latch is_store, clear counter; non-memory -> stay IDLE.
REQ-015 ACCESS: mem_ack=1 -> DONE; else counter==TIMEOUT-1 -> ERR; else counter+1, stay.
REQ-016 mem_ack in the final ACCESS cycle (counter==TIMEOUT-1) SHALL win over timeout: -> DONE.
REQ-017 DONE: unconditional -> IDLE after one cycle.
REQ-018 ERR: absorbing; exits only via rst.
REQ-019 mem_ack in IDLE, DONE or ERR SHALL be ignored.
REQ-020 mem_req SHALL be 1 iff state==ACCESS, decoded from state flops only.
REQ-021 mem_we SHALL equal is_store while in ACCESS, 0 otherwise.
REQ-022 pc_enable SHALL be 1 iff (IDLE and opcode non-memory) or DONE; combinational from state and opcode.
REQ-023 pc_enable SHALL be 0 in the IDLE cycle a load/store is decoded, throughout ACCESS, and in ERR.
REQ-024 reg_write_load SHALL equal pc_enable in every state.
REQ-025 busy SHALL be 1 iff state is ACCESS or DONE.
REQ-026 bus_err SHALL be 1 iff state==ERR.
REQ-027 Counter width SHALL be $clog2(TIMEOUT+1); counter SHALL never wrap.
REQ-028 Memory instruction stall SHALL be 1 + (ACCESS cycles) cycles; back-to-back memory instructions SHALL each re-enter via IDLE.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, counter 0, is_store 0, without waiting for clk.
REQ-030 During/after reset: mem_req=0, mem_we=0, busy=0, bus_err=0; pc_enable and reg_write_load follow opcode per REQ-022.
REQ-031 Reset asserted mid-ACCESS SHALL drop mem_req in the same cycle; the aborted access SHALL not produce DONE.

Structure
REQ-032 Shared package SHALL hold OP_LOAD (5'b00000), OP_STORE (5'b01000) and the state enumeration.
REQ-033 Timeout counter SHALL be one sub-module, timeout_counter (clear, enable, terminal-count output).

Verification
REQ-034 rst=1, opcode=0110011 -> pc_enable=1, reg_write_load=1, mem_req=0, busy=0, bus_err=0.
REQ-035 Load 0000011, mem_ack in 3rd ACCESS cycle -> pc_enable low 4 cycles, DONE with pc_enable=1, reg_write_load=1, mem_we=0 throughout.
REQ-036 Store 0100011, mem_ack in 1st ACCESS cycle -> mem_req=1 and mem_we=1 for 1 cycle, pc_enable low 2 cycles.
REQ-037 TIMEOUT=4, load, no mem_ack -> mem_req high 4 cycles, then bus_err=1, pc_enable=0 held until rst.
REQ-038 TIMEOUT=4, mem_ack in 4th ACCESS cycle -> DONE, bus_err stays 0.
REQ-039 rst pulsed in 2nd ACCESS cycle -> mem_req=0 same cycle, state IDLE, no DONE pulse observed.
